program_memory: RTL and testbench

Parametrised, loadable program memory for the F100-L soft processor. It replaces the fixed instruction image with a synchronous single-port RAM of `2**ADDR_WIDTH` words. The core fetches through a registered read port. A byte-serial loader (fed by the UART/SPI front end) writes a new program image at runtime, without rebuilding the bitstream.

---
 rtl/program_memory.sv | 222 ++++++++++++++++++++++
 tb/tb_program_memory.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/program_memory.sv
// rtl/program_memory.sv - loadable single-port program memory with byte-serial loader (optional checksum: PROGRAM_MEMORY_CHECKSUM_EN)
module program_memory #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] fetch_address,
  input  logic                  fetch_enable,
  output logic [DATA_WIDTH-1:0] fetch_data,
  output logic                  fetch_valid,
  input  logic                  load_start,
  input  logic [7:0]            load_byte,
  input  logic                  load_byte_valid,
  output logic                  loading,
  output logic                  load_ok,
  output logic                  load_error
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int ASMW  = (BYTES > 1) ? DATA_WIDTH - 8 : 8;
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(BYTES - 1);

`ifdef PROGRAM_MEMORY_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CHK, S_DONE
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_DONE
  } state_t;
`endif

  state_t                r_state;
  state_t                w_state_next;
  logic [15:0]           r_len;
  logic [ADDR_WIDTH:0]   r_ptr;
  logic [BCW-1:0]        r_byte_cnt;
  logic [ASMW-1:0]       r_asm;
  logic                  r_loading;
  logic                  r_ok;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_fetch_data;
  logic                  r_fetch_valid;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
`ifdef PROGRAM_MEMORY_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] r_csum;
`endif

  logic [15:0]           w_len;
  logic [DATA_WIDTH-1:0] w_word;
  logic                  w_accept;
  logic                  w_last_byte;
  logic                  w_last_word;
  logic                  w_oversize;
  logic                  w_in_word;
  logic                  w_mem_we;
  logic                  w_finish_ok;
  logic                  w_finish_err;

  // A restart pulse takes priority: any byte offered in the same cycle is dropped.
  assign w_accept    = load_byte_valid && !load_start;
  assign w_len       = {r_len[15:8], load_byte};
  assign w_last_byte = (r_byte_cnt == LAST_BYTE);
  assign w_last_word = (32'(r_ptr) + 32'd1) == 32'(r_len);
  assign w_oversize  = 32'(w_len) > 32'(DEPTH);

  // The word being completed always includes the byte currently on the bus.
  generate
    if (BYTES == 1) begin : g_word_1
      assign w_word = load_byte;
    end else begin : g_word_n
      assign w_word = {r_asm, load_byte};
    end
  endgenerate

`ifdef PROGRAM_MEMORY_CHECKSUM_EN
  assign w_in_word = (r_state == S_DATA) || (r_state == S_CHK);
`else
  assign w_in_word = (r_state == S_DATA);
`endif

  // Loader next-state, RAM write strobe and session completion decisions
  always_comb begin
    w_state_next = r_state;
    w_mem_we     = 1'b0;
    w_finish_ok  = 1'b0;
    w_finish_err = 1'b0;
    if (load_start) begin
      w_state_next = S_LEN_HI;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_next = S_IDLE;
        end
        S_LEN_HI: begin
          if (load_byte_valid) w_state_next = S_LEN_LO;
        end
        S_LEN_LO: begin
          if (load_byte_valid) begin
            if (w_oversize) begin
              w_state_next = S_DONE;
              w_finish_err = 1'b1;
            end else if (w_len == 16'd0) begin
`ifdef PROGRAM_MEMORY_CHECKSUM_EN
              w_state_next = S_CHK;
`else
              w_state_next = S_DONE;
              w_finish_ok  = 1'b1;
`endif
            end else begin
              w_state_next = S_DATA;
            end
          end
        end
        S_DATA: begin
          if (load_byte_valid && w_last_byte) begin
            w_mem_we = 1'b1;
            if (w_last_word) begin
`ifdef PROGRAM_MEMORY_CHECKSUM_EN
              w_state_next = S_CHK;
`else
              w_state_next = S_DONE;
              w_finish_ok  = 1'b1;
`endif
            end
          end
        end
`ifdef PROGRAM_MEMORY_CHECKSUM_EN
        S_CHK: begin
          if (load_byte_valid && w_last_byte) begin
            w_state_next = S_DONE;
            if (w_word == r_csum) w_finish_ok = 1'b1;
            else                  w_finish_err = 1'b1;
          end
        end
`endif
        S_DONE: begin
          w_state_next = S_IDLE;
        end
        default: begin
          w_state_next = S_IDLE;
        end
      endcase
    end
  end

  // Loader state, session bookkeeping and sticky status flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_len      <= '0;
      r_ptr      <= '0;
      r_byte_cnt <= '0;
      r_asm      <= '0;
      r_loading  <= 1'b0;
      r_ok       <= 1'b0;
      r_err      <= 1'b0;
`ifdef PROGRAM_MEMORY_CHECKSUM_EN
      r_csum     <= '0;
`endif
    end else begin
      r_state <= w_state_next;
      if (load_start) begin
        r_loading  <= 1'b1;
        r_ok       <= 1'b0;
        r_err      <= 1'b0;
        r_ptr      <= '0;
        r_byte_cnt <= '0;
        r_asm      <= '0;
`ifdef PROGRAM_MEMORY_CHECKSUM_EN
        r_csum     <= '0;
`endif
      end else begin
        if (w_finish_ok || w_finish_err) begin
          r_loading <= 1'b0;
          r_ok      <= w_finish_ok;
          r_err     <= w_finish_err;
        end
        if (w_accept && r_state == S_LEN_HI) r_len[15:8] <= load_byte;
        if (w_accept && r_state == S_LEN_LO) r_len[7:0]  <= load_byte;
        if (w_accept && w_in_word) begin
          r_byte_cnt <= w_last_byte ? '0 : r_byte_cnt + 1'b1;
          r_asm      <= w_word[ASMW-1:0];
        end
        if (w_mem_we) begin
          r_ptr  <= r_ptr + 1'b1;
`ifdef PROGRAM_MEMORY_CHECKSUM_EN
          r_csum <= r_csum + w_word;
`endif
        end
      end
    end
  end

  // Program RAM write port; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[r_ptr[ADDR_WIDTH-1:0]] <= w_word;
  end

  // Registered fetch port, refused while a load session owns the RAM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_data  <= '0;
      r_fetch_valid <= 1'b0;
    end else if (!r_loading && fetch_enable) begin
      r_fetch_data  <= r_mem[fetch_address];
      r_fetch_valid <= 1'b1;
    end else begin
      r_fetch_valid <= 1'b0;
    end
  end

  assign fetch_data  = r_fetch_data;
  assign fetch_valid = r_fetch_valid;
  assign loading     = r_loading;
  assign load_ok     = r_ok;
  assign load_error  = r_err;

endmodule

// File: tb/tb_program_memory.sv
// tb/tb_program_memory.sv - scoreboard bench for program_memory (honours PROGRAM_MEMORY_CHECKSUM_EN)
module tb_program_memory;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  fetch_address = '0;
  logic        fetch_enable = 1'b0;
  logic [15:0] fetch_data;
  logic        fetch_valid;
  logic        load_start = 1'b0;
  logic [7:0]  load_byte = '0;
  logic        load_byte_valid = 1'b0;
  logic        loading;
  logic        load_ok;
  logic        load_error;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic        care;
    logic [15:0] data;
  } exp_t;
  exp_t sb[$];

  program_memory #(.ADDR_WIDTH(10), .DATA_WIDTH(16)) dut (
    .clk(clk), .reset(reset),
    .fetch_address(fetch_address), .fetch_enable(fetch_enable),
    .fetch_data(fetch_data), .fetch_valid(fetch_valid),
    .load_start(load_start), .load_byte(load_byte), .load_byte_valid(load_byte_valid),
    .loading(loading), .load_ok(load_ok), .load_error(load_error)
  );

  always #5 clk = ~clk;

  // fetch monitor: every valid fetch must match the oldest queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (!reset && fetch_valid) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_errors++;
        $display("FAIL sb_unexpected_fetch: got data %h with nothing expected", fetch_data);
      end else begin
        e = sb.pop_front();
        if (e.care && fetch_data !== e.data) begin
          n_errors++;
          $display("FAIL sb_fetch_data: got %h expected %h", fetch_data, e.data);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic start_session;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    load_byte = b;
    load_byte_valid = 1'b1;
    tick();
    load_byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic send_csum(input logic [15:0] c);
`ifdef PROGRAM_MEMORY_CHECKSUM_EN
    send_word(c);
`else
    if (c === 16'hxxxx) $display("unreachable");
`endif
  endtask

  task automatic fetch(input logic [9:0] a, input logic [15:0] e);
    fetch_address = a;
    fetch_enable = 1'b1;
    sb.push_back('{1'b1, e});
    tick();
  endtask

  task automatic idle;
    fetch_enable = 1'b0;
    tick();
    tick();
  endtask

  task automatic chk_status(input string name, input logic l, input logic ok, input logic er);
    chk({name, "_loading"}, 32'(loading), 32'(l));
    chk({name, "_load_ok"}, 32'(load_ok), 32'(ok));
    chk({name, "_load_error"}, 32'(load_error), 32'(er));
  endtask

  initial begin
    logic [7:0]  fb[$];
    logic [15:0] csum;

    // reset state
    repeat (3) tick();
    chk("rst_fetch_data", 32'(fetch_data), 32'h0);
    chk("rst_fetch_valid", 32'(fetch_valid), 32'h0);
    chk_status("rst", 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    tick();
    fetch_address = 10'd5;
    fetch_enable = 1'b1;
    sb.push_back('{1'b0, 16'h0});
    tick();
    chk("post_rst_fetch_valid", 32'(fetch_valid), 32'h1);
    idle();

    // basic load
    start_session();
    chk_status("basic_start", 1'b1, 1'b0, 1'b0);
    send_word(16'h0003);
    send_word(16'h8000);
    send_word(16'h0F01);
    send_word(16'h0400);
    send_csum(16'h9301);
    chk_status("basic_end", 1'b0, 1'b1, 1'b0);
    fetch(10'd2, 16'h0400);
    chk("basic_latency_valid", 32'(fetch_valid), 32'h1);
    fetch(10'd0, 16'h8000);
    fetch(10'd1, 16'h0F01);
    idle();

    // oversize length rejected on the LEN_LO byte
    start_session();
    send_word(16'h0401);
    chk_status("oversize", 1'b0, 1'b0, 1'b1);
    fetch(10'd0, 16'h8000);
    fetch(10'd1, 16'h0F01);
    fetch(10'd2, 16'h0400);
    idle();

`ifdef PROGRAM_MEMORY_CHECKSUM_EN
    // checksum mismatch keeps the written words
    start_session();
    send_word(16'h0003);
    send_word(16'h8000);
    send_word(16'h0F01);
    send_word(16'h0400);
    send_word(16'h9302);
    chk_status("csum_bad", 1'b0, 1'b0, 1'b1);
    fetch(10'd0, 16'h8000);
    fetch(10'd1, 16'h0F01);
    fetch(10'd2, 16'h0400);
    idle();
`endif

    // restart mid-DATA with a colliding byte that must be dropped
    start_session();
    send_word(16'h0002);
    send_word(16'hAAAA);
    send_byte(8'hBB);
    load_byte = 8'hCC;
    load_byte_valid = 1'b1;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    load_byte_valid = 1'b0;
    chk_status("restart_edge", 1'b1, 1'b0, 1'b0);
    send_word(16'h0001);
    send_word(16'h1234);
    send_csum(16'h1234);
    chk_status("restart_end", 1'b0, 1'b1, 1'b0);
    fetch(10'd0, 16'h1234);
    fetch(10'd1, 16'h0F01);
    idle();

    // zero-length session
    start_session();
    send_word(16'h0000);
    send_csum(16'h0000);
    chk_status("zero_len", 1'b0, 1'b1, 1'b0);
    fetch(10'd0, 16'h1234);
    idle();

    // fetch held high throughout a session
    fb = '{8'h00, 8'h01, 8'h56, 8'h78};
`ifdef PROGRAM_MEMORY_CHECKSUM_EN
    fb.push_back(8'h56);
    fb.push_back(8'h78);
`endif
    fetch_address = 10'd1;
    fetch_enable = 1'b1;
    load_start = 1'b1;
    sb.push_back('{1'b1, 16'h0F01});
    tick();
    load_start = 1'b0;
    chk("hold_loading_up", 32'(loading), 32'h1);
    fetch_address = 10'd0;
    foreach (fb[i]) begin
      send_byte(fb[i]);
      chk($sformatf("hold_valid_b%0d", i), 32'(fetch_valid), 32'h0);
      chk($sformatf("hold_data_b%0d", i), 32'(fetch_data), 32'h0F01);
    end
    chk_status("hold_end", 1'b0, 1'b1, 1'b0);
    sb.push_back('{1'b1, 16'h5678});
    tick();
    fetch_enable = 1'b0;
    chk("hold_valid_back", 32'(fetch_valid), 32'h1);
    chk("hold_data_back", 32'(fetch_data), 32'h5678);
    idle();

    // full-depth load, no pointer wrap
    start_session();
    send_word(16'h0400);
    csum = 16'h0;
    for (int i = 0; i < 1024; i++) begin
      send_word(16'(i * 37 + 4096));
      csum = csum + 16'(i * 37 + 4096);
    end
    send_csum(csum);
    chk_status("full", 1'b0, 1'b1, 1'b0);
    fetch(10'd0, 16'(4096));
    fetch(10'd1, 16'(37 + 4096));
    fetch(10'd512, 16'(512 * 37 + 4096));
    fetch(10'd1023, 16'(1023 * 37 + 4096));
    idle();

    chk("sb_drain", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
